// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Sequential instruction prefetcher. It issues one word fetch
//                at a time and buffers {pc, instr} pairs in a DEPTH-entry FIFO
//                that the decode stage drains. A redirect flushes the FIFO and
//                restarts fetch, and any in-flight response is discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_instr,
  output logic                   mem_ready,
  input  logic                   mem_valid,
  output logic [XLEN-1:0]        mem_addr,
  output logic                   mem_instr,
  output logic [3:0]             mem_wstrb,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int                c_PTR_W     = $clog2(DEPTH);
  localparam int                c_CNT_W     = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]    c_WORD      = XLEN'(4);
  localparam logic [XLEN-1:0]    c_ALIGN     = {{(XLEN-2){1'b1}}, 2'b00};

  // Request tracker: BUSY keeps the response, DROP discards it because a
  // redirect arrived while it was in flight.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_issue;
  logic [XLEN-1:0]     w_issue_addr;
  logic [XLEN-1:0]     w_redirect_pc;
  logic                w_push;
  logic                w_pop;

  logic [XLEN-1:0]     r_fetch_pc;
  logic [XLEN-1:0]     r_mem_addr;
  logic [c_PTR_W-1:0]  r_head;
  logic [c_PTR_W-1:0]  r_tail;
  logic [c_CNT_W-1:0]  r_count;
  logic [XLEN-1:0]     r_fifo_pc    [DEPTH];
  logic [XLEN-1:0]     r_fifo_instr [DEPTH];

  assign w_redirect_pc = redirect_pc & c_ALIGN;
  // A response lands in the FIFO only if it was not invalidated, either
  // earlier (DROP) or by a redirect in the completing cycle.
  assign w_push        = (r_state == ST_BUSY) && mem_valid && !redirect_valid;
  // A redirect voids any pop in the same cycle.
  assign w_pop         = (r_count != '0) && out_ready && !redirect_valid;

  assign out_valid = (r_count != '0);
  assign out_pc    = r_fifo_pc[r_head];
  assign out_instr = r_fifo_instr[r_head];
  assign count     = r_count;
  assign mem_ready = (r_state != ST_IDLE);
  assign mem_instr = mem_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = 4'b0000;

  // Request tracker state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next request state and issue decision. An idle tracker issues when the
  // FIFO has a free slot; the in-flight request already holds its slot, so
  // a completed response always fits. A redirect while idle issues at once.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_fetch_pc;
    case (r_state)
      ST_IDLE: begin
        if (redirect_valid) begin
          w_state_next = ST_BUSY;
          w_issue      = 1'b1;
          w_issue_addr = w_redirect_pc;
        end else if (r_count < c_DEPTH_CNT) begin
          w_state_next = ST_BUSY;
          w_issue      = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_valid) begin
          w_state_next = ST_IDLE;
        end else if (redirect_valid) begin
          w_state_next = ST_DROP;
        end
      end
      ST_DROP: begin
        if (mem_valid) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Request address is captured at issue and held until completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_addr <= '0;
    end else if (w_issue) begin
      r_mem_addr <= w_issue_addr;
    end
  end

  // Next sequential fetch address; a redirect overrides the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
    end else if (w_push) begin
      r_fetch_pc <= r_mem_addr + c_WORD;
    end
  end

  // FIFO pointers and occupancy; full/empty come from the count, pointers
  // simply wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      if (w_push) begin
        r_tail <= r_tail + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since out_valid gates them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_tail]    <= r_mem_addr;
      r_fifo_instr[r_tail] <= mem_rdata;
    end
  end

endmodule
`default_nettype wire
